sram_1w1r_bytemask_pipe: RTL and testbench
==========================================

Name: sram_1w1r_bytemask_pipe

Overview:
- Synthesisable, parametrised single-clock 1-write/1-read SRAM model. Successor to the fixed 16x32 dual-clock OpenRAM behavioural macros.
- Adds per-byte write mask, a configurable read pipeline and a defined read-during-write collision policy.
- Adds a reset-driven initialisation sweep with a ready flag.
- Drop-in storage for FIFOs and buffers in FreePDK45 flows, where a macro is not generated.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- RAM_DEPTH, 16, number of words; any value >= 2.
- ADDR_WIDTH, $clog2(RAM_DEPTH), address width.
- READ_LATENCY, 1, cycles from accepted read to dout1_valid; legal 1..3.
- BYPASS, 1, collision policy: 1 = read returns newly written (merged) data; 0 = read returns old data.
- INIT_VALUE, 0, word written to every location during the init sweep.

Ports:
- clk  in  1  single clock; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high when the init sweep is complete and requests are accepted.
- csb0  in  1  active-low write select.
- addr0  in  ADDR_WIDTH  write address.
- din0  in  DATA_WIDTH  write data.
- wmask0  in  DATA_WIDTH/8  byte enables; bit i covers din0[8i+7:8i].
- csb1  in  1  active-low read select.
- addr1  in  ADDR_WIDTH  read address.
- dout1  out  DATA_WIDTH  read data.
- dout1_valid  out  1  one-cycle strobe marking valid dout1.
- collision  out  1  aligned with dout1_valid; the read hit a same-cycle write to the same address.
- addr_err  out  1  one-cycle pulse, one cycle after any accepted request whose address is >= RAM_DEPTH.

Behaviour:
- Reset values: ready=0, dout1=0, dout1_valid=0, collision=0, addr_err=0. All read-pipeline valid bits are cleared. The FSM enters INIT with init_cnt=0.
- FSM INIT: each cycle writes INIT_VALUE (all bytes) to mem[init_cnt], then increments init_cnt. When init_cnt==RAM_DEPTH-1 is written, the FSM moves to READY next cycle. The sweep therefore takes exactly RAM_DEPTH cycles after rst deasserts.
- While in INIT, csb0/csb1 are ignored: no write, no valid, no addr_err.
- FSM READY: ready=1. The FSM leaves READY only via rst.
- rst asserted in any state, including mid-read-pipeline: on the next edge the block returns to INIT and restarts the sweep. In-flight reads are dropped with no valid strobe. Memory contents are re-initialised.
- Write (ready & !csb0 & addr0<RAM_DEPTH): at the posedge, bytes with wmask0[i]=1 update mem[addr0]; other bytes are unchanged. wmask0=0 is a legal no-op.
- Read (ready & !csb1 & addr1<RAM_DEPTH): the array is sampled at the accepting posedge. Data then passes through READ_LATENCY-1 further registers. dout1_valid is high exactly READ_LATENCY cycles after the request cycle. Back-to-back reads give one result per cycle.
- dout1 holds its last value when dout1_valid=0. It is never X.
- Collision (same cycle, both accepted, addr0==addr1):
  - BYPASS=1: dout1 = bytes from din0 where wmask0=1, old memory bytes elsewhere.
  - BYPASS=0: dout1 = old word.
  - In both cases collision=1 with the matching valid.
- Out-of-range address (RAM_DEPTH not a power of two):
  - Write is dropped.
  - Read produces a valid strobe with dout1=INIT_VALUE.
  - addr_err pulses in either case.
- Simultaneous write and read to different addresses: independent; no interaction.

Decomposition:
- Package sram_pkg holds:
  - state enum {INIT, READY};
  - function byte_merge(old, new, mask);
  - localparam NUM_BYTES = DATA_WIDTH/8.
- Sub-module sram_rd_pipe carries data, valid and collision through READ_LATENCY stages with synchronous clear.
- The top level holds the array, FSM, write logic and collision compare.

Test Plan:
- Reset sweep, RAM_DEPTH=16: deassert rst -> ready rises after exactly 16 cycles. Read all addresses -> every dout1=INIT_VALUE, valid after READ_LATENCY.
- Masked write: write 0xFFFFFFFF with mask 0xF to addr 3, then 0x12345678 with mask 0b0101 to addr 3, then read addr 3 -> 0xFF34FF78, collision=0.
- Collision, BYPASS=1: mem[5]=0xAAAAAAAA. Same-cycle write 0x11223344 mask 0b0011 and read of addr 5 -> dout1=0xAAAA3344, collision=1. With BYPASS=0 -> dout1=0xAAAAAAAA, collision=1.
- Pipeline, READ_LATENCY=3: reads to addr 0,1,2 on consecutive cycles -> three consecutive valids, first one 3 cycles after the first request, data in order.
- Reset mid-operation: issue a read, assert rst one cycle later -> no dout1_valid. ready=0, then ready re-rises after RAM_DEPTH cycles, and a prior write is no longer visible (reads INIT_VALUE).
- Out of range, RAM_DEPTH=12: write addr 13, read addr 13 -> addr_err pulses for each, read returns INIT_VALUE, mem[0..11] unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1W1R byte-masked SRAM model.
package sram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned MAX_DATA_WIDTH = 512;
    localparam int unsigned MAX_NUM_BYTES  = MAX_DATA_WIDTH / 8;

    // Callers zero-extend into the maximum width and truncate the result back.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_NUM_BYTES-1:0]  mask
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_NUM_BYTES; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_1w1r_bytemask_pipe_if.sv
// Request/response bundle for the 1W1R byte-masked SRAM.
interface sram_1w1r_bytemask_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                    ready;
    logic                    csb0;
    logic [ADDR_WIDTH-1:0]   addr0;
    logic [DATA_WIDTH-1:0]   din0;
    logic [DATA_WIDTH/8-1:0] wmask0;
    logic                    csb1;
    logic [ADDR_WIDTH-1:0]   addr1;
    logic [DATA_WIDTH-1:0]   dout1;
    logic                    dout1_valid;
    logic                    collision;
    logic                    addr_err;

    modport master (
        input  ready, dout1, dout1_valid, collision, addr_err,
        output csb0, addr0, din0, wmask0, csb1, addr1
    );

    modport slave (
        output ready, dout1, dout1_valid, collision, addr_err,
        input  csb0, addr0, din0, wmask0, csb1, addr1
    );
endinterface

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: carries data, valid and collision through READ_LATENCY
// registers; data stages only load on valid so the output holds between strobes.
module sram_rd_pipe #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_coll,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_coll,
    output logic [DATA_WIDTH-1:0] out_data
);
    logic [READ_LATENCY-1:0]                 vld_q,  vld_d;
    logic [READ_LATENCY-1:0]                 coll_q, coll_d;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] data_q, data_d;

    // Index 0 of each chain is the pipe input, index g+1 is stage g.
    logic [READ_LATENCY:0]                 vld_chain;
    logic [READ_LATENCY:0]                 coll_chain;
    logic [READ_LATENCY:0][DATA_WIDTH-1:0] data_chain;

    assign vld_chain  = {vld_q, in_valid};
    assign coll_chain = {coll_q, in_coll};
    assign data_chain = {data_q, in_data};

    always_comb begin
        vld_d  = vld_chain[READ_LATENCY-1:0];
        coll_d = vld_chain[READ_LATENCY-1:0] & coll_chain[READ_LATENCY-1:0];
    end

    for (genvar g = 0; g < READ_LATENCY; g++) begin : g_stage
        assign data_d[g] = vld_chain[g] ? data_chain[g] : data_q[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            coll_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            coll_q <= coll_d;
            data_q <= data_d;
        end
    end

    assign out_valid = vld_q[READ_LATENCY-1];
    assign out_coll  = coll_q[READ_LATENCY-1];
    assign out_data  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/sram_1w1r_bytemask_pipe.sv
// Single-clock 1W1R SRAM model with byte mask, init sweep, configurable read
// latency and a selectable read-during-write policy.
module sram_1w1r_bytemask_pipe
    import sram_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH   = 32,
    parameter int unsigned         RAM_DEPTH    = 16,
    parameter int unsigned         ADDR_WIDTH   = $clog2(RAM_DEPTH),
    parameter int unsigned         READ_LATENCY = 1,
    parameter bit                  BYPASS       = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic                     clk,
    input logic                     rst,
    sram_1w1r_bytemask_pipe_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    ready_q, ready_d;
    logic                    addr_err_q, addr_err_d;

    logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];

    logic                    wr_acc, wr_hit, rd_acc, rd_hit, coll_hit;
    logic [ADDR_WIDTH-1:0]   wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]   wr_old, wr_merged, rd_word, rd_data;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Request decode; out-of-range addresses are steered to word 0 but never used.
    always_comb begin
        wr_acc   = (state_q == READY) && !bus.csb0;
        rd_acc   = (state_q == READY) && !bus.csb1;
        wr_hit   = wr_acc && ({1'b0, bus.addr0} < DEPTH_L);
        rd_hit   = rd_acc && ({1'b0, bus.addr1} < DEPTH_L);
        coll_hit = wr_hit && rd_hit && (bus.addr0 == bus.addr1);
        wr_idx   = wr_hit ? bus.addr0 : '0;
        rd_idx   = rd_hit ? bus.addr1 : '0;
    end

    assign wr_old    = mem_q[wr_idx];
    assign rd_word   = mem_q[rd_idx];
    assign wr_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(wr_old),
                                              MAX_DATA_WIDTH'(bus.din0),
                                              MAX_NUM_BYTES'(bus.wmask0)));

    // On a collision the merged word equals what the array will hold after the edge.
    always_comb begin
        rd_data = rd_word;
        if (!rd_hit) begin
            rd_data = INIT_VALUE;
        end else if (coll_hit && BYPASS) begin
            rd_data = wr_merged;
        end
    end

    // Next state, init sweep and array write port.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_idx;
        mem_wdata  = wr_merged;
        addr_err_d = (wr_acc && !wr_hit) || (rd_acc && !rd_hit);
        if (state_q == INIT) begin
            mem_we     = 1'b1;
            mem_waddr  = init_cnt_q;
            mem_wdata  = INIT_VALUE;
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
            if (init_cnt_q == LAST_IDX) begin
                state_d = READY;
            end
        end else begin
            mem_we = wr_hit;
        end
        if (rst) begin
            mem_we = 1'b0;
        end
        ready_d = (state_d == READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    sram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_acc),
        .in_coll  (coll_hit),
        .in_data  (rd_data),
        .out_valid(bus.dout1_valid),
        .out_coll (bus.collision),
        .out_data (bus.dout1)
    );

    assign bus.ready    = ready_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_sram_1w1r_bytemask_pipe.sv
// Directed bench: instance A (depth 16, latency 1, bypass) and instance B
// (depth 12, latency 3, no bypass, INIT_VALUE 0xDEADBEEF) on a shared clock/reset.
module tb_sram_1w1r_bytemask_pipe;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    sram_1w1r_bytemask_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_a ();
    sram_1w1r_bytemask_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_b ();

    sram_1w1r_bytemask_pipe #(
        .DATA_WIDTH(32), .RAM_DEPTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1),
        .BYPASS(1'b1), .INIT_VALUE(32'h0000_0000)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );

    sram_1w1r_bytemask_pipe #(
        .DATA_WIDTH(32), .RAM_DEPTH(12), .ADDR_WIDTH(4), .READ_LATENCY(3),
        .BYPASS(1'b0), .INIT_VALUE(32'hDEAD_BEEF)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request cycle, then advance to the following negedge.
    task automatic drv_a(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] wm, input logic re, input logic [3:0] ra);
        if_a.csb0 = ~we; if_a.addr0 = wa; if_a.din0 = wd; if_a.wmask0 = wm;
        if_a.csb1 = ~re; if_a.addr1 = ra;
        @(negedge clk);
    endtask

    task automatic drv_b(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] wm, input logic re, input logic [3:0] ra);
        if_b.csb0 = ~we; if_b.addr0 = wa; if_b.din0 = wd; if_b.wmask0 = wm;
        if_b.csb1 = ~re; if_b.addr1 = ra;
        @(negedge clk);
    endtask

    logic [31:0] exp_b [12];

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        if_a.csb0 = 1'b1; if_a.addr0 = '0; if_a.din0 = '0; if_a.wmask0 = '0;
        if_a.csb1 = 1'b1; if_a.addr1 = '0;
        if_b.csb0 = 1'b1; if_b.addr0 = '0; if_b.din0 = '0; if_b.wmask0 = '0;
        if_b.csb1 = 1'b1; if_b.addr1 = '0;
        repeat (2) @(negedge clk);

        chk("rst_a_ready", 32'(if_a.ready), 32'd0);
        chk("rst_a_dout", if_a.dout1, 32'd0);
        chk("rst_a_valid", 32'(if_a.dout1_valid), 32'd0);
        chk("rst_a_coll", 32'(if_a.collision), 32'd0);
        chk("rst_a_aerr", 32'(if_a.addr_err), 32'd0);
        chk("rst_b_ready", 32'(if_b.ready), 32'd0);
        chk("rst_b_dout", if_b.dout1, 32'd0);

        // Sweep; A requests during INIT must be ignored.
        rst = 1'b0;
        if_a.csb0 = 1'b0; if_a.addr0 = 4'd2; if_a.din0 = 32'hFFFF_FFFF; if_a.wmask0 = 4'hF;
        if_a.csb1 = 1'b0; if_a.addr1 = 4'd2;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("sweep_a_ready", 32'(if_a.ready), 32'(i >= 16));
            chk("sweep_b_ready", 32'(if_b.ready), 32'(i >= 12));
            chk("sweep_a_valid", 32'(if_a.dout1_valid), 32'd0);
            chk("sweep_a_aerr", 32'(if_a.addr_err), 32'd0);
        end
        if_a.csb0 = 1'b1; if_a.csb1 = 1'b1;

        // A: back-to-back readback of every word.
        for (int k = 0; k < 16; k++) begin
            drv_a(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(k));
            chk("a_init_valid", 32'(if_a.dout1_valid), 32'd1);
            chk("a_init_data", if_a.dout1, 32'd0);
            chk("a_init_coll", 32'(if_a.collision), 32'd0);
        end
        drv_a(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("a_idle_valid", 32'(if_a.dout1_valid), 32'd0);

        // A: masked writes and mask-0 no-op.
        drv_a(1'b1, 4'd3, 32'hFFFF_FFFF, 4'hF, 1'b0, 4'd0);
        chk("a_wr_aerr", 32'(if_a.addr_err), 32'd0);
        drv_a(1'b1, 4'd3, 32'h1234_5678, 4'b0101, 1'b0, 4'd0);
        drv_a(1'b1, 4'd3, 32'h0000_0000, 4'b0000, 1'b0, 4'd0);
        drv_a(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
        chk("a_mask_valid", 32'(if_a.dout1_valid), 32'd1);
        chk("a_mask_data", if_a.dout1, 32'hFF34_FF78);
        chk("a_mask_coll", 32'(if_a.collision), 32'd0);

        // A: same-cycle collision with bypass, then independent addresses.
        drv_a(1'b1, 4'd5, 32'hAAAA_AAAA, 4'hF, 1'b0, 4'd0);
        drv_a(1'b1, 4'd5, 32'h1122_3344, 4'b0011, 1'b1, 4'd5);
        chk("a_coll_data", if_a.dout1, 32'hAAAA_3344);
        chk("a_coll_flag", 32'(if_a.collision), 32'd1);
        drv_a(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5);
        chk("a_after_coll_data", if_a.dout1, 32'hAAAA_3344);
        chk("a_after_coll_flag", 32'(if_a.collision), 32'd0);
        drv_a(1'b1, 4'd6, 32'h0BAD_F00D, 4'hF, 1'b1, 4'd3);
        chk("a_indep_data", if_a.dout1, 32'hFF34_FF78);
        chk("a_indep_coll", 32'(if_a.collision), 32'd0);
        drv_a(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd6);
        chk("a_indep_wr", if_a.dout1, 32'h0BAD_F00D);
        drv_a(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("a_hold_valid", 32'(if_a.dout1_valid), 32'd0);
        chk("a_hold_data", if_a.dout1, 32'h0BAD_F00D);
        drv_a(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2);
        chk("a_init_wr_ignored", if_a.dout1, 32'd0);
        drv_a(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);

        // B: latency-3 pipeline, three consecutive reads.
        drv_b(1'b1, 4'd1, 32'h1111_1111, 4'hF, 1'b0, 4'd0);
        drv_b(1'b1, 4'd2, 32'h2222_2222, 4'hF, 1'b0, 4'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd0);
        chk("b_pipe_v1", 32'(if_b.dout1_valid), 32'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd1);
        chk("b_pipe_v2", 32'(if_b.dout1_valid), 32'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2);
        chk("b_pipe_v3", 32'(if_b.dout1_valid), 32'd1);
        chk("b_pipe_d0", if_b.dout1, 32'hDEAD_BEEF);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_pipe_v4", 32'(if_b.dout1_valid), 32'd1);
        chk("b_pipe_d1", if_b.dout1, 32'h1111_1111);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_pipe_v5", 32'(if_b.dout1_valid), 32'd1);
        chk("b_pipe_d2", if_b.dout1, 32'h2222_2222);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_pipe_v6", 32'(if_b.dout1_valid), 32'd0);
        chk("b_pipe_hold", if_b.dout1, 32'h2222_2222);

        // B: collision without bypass returns the old word.
        drv_b(1'b1, 4'd5, 32'hAAAA_AAAA, 4'hF, 1'b0, 4'd0);
        drv_b(1'b1, 4'd5, 32'h1122_3344, 4'b0011, 1'b1, 4'd5);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_coll_valid", 32'(if_b.dout1_valid), 32'd1);
        chk("b_coll_data", if_b.dout1, 32'hAAAA_AAAA);
        chk("b_coll_flag", 32'(if_b.collision), 32'd1);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_after_coll_data", if_b.dout1, 32'hAAAA_3344);
        chk("b_after_coll_flag", 32'(if_b.collision), 32'd0);

        // B: out-of-range write and read at address 13.
        drv_b(1'b1, 4'd13, 32'h5555_5555, 4'hF, 1'b0, 4'd0);
        chk("b_oor_wr_aerr", 32'(if_b.addr_err), 32'd1);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_oor_aerr_clr", 32'(if_b.addr_err), 32'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd13);
        chk("b_oor_rd_aerr", 32'(if_b.addr_err), 32'd1);
        chk("b_oor_rd_v1", 32'(if_b.dout1_valid), 32'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_oor_aerr_clr2", 32'(if_b.addr_err), 32'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_oor_rd_valid", 32'(if_b.dout1_valid), 32'd1);
        chk("b_oor_rd_data", if_b.dout1, 32'hDEAD_BEEF);
        chk("b_oor_rd_coll", 32'(if_b.collision), 32'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);

        // B: whole array unchanged by the dropped write.
        for (int k = 0; k < 12; k++) exp_b[k] = 32'hDEAD_BEEF;
        exp_b[1] = 32'h1111_1111;
        exp_b[2] = 32'h2222_2222;
        exp_b[5] = 32'hAAAA_3344;
        for (int j = 0; j < 14; j++) begin
            drv_b(1'b0, 4'd0, 32'd0, 4'd0, j < 12, 4'(j));
            if (j >= 2) begin
                chk("b_scan_valid", 32'(if_b.dout1_valid), 32'd1);
                chk("b_scan_data", if_b.dout1, exp_b[j-2]);
            end
        end
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_scan_aerr", 32'(if_b.addr_err), 32'd0);

        // B: reset one cycle after a read drops it and re-initialises memory.
        drv_b(1'b1, 4'd4, 32'h4444_4444, 4'hF, 1'b0, 4'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd4);
        rst = 1'b1;
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_rst_valid", 32'(if_b.dout1_valid), 32'd0);
        chk("b_rst_ready", 32'(if_b.ready), 32'd0);
        chk("b_rst_dout", if_b.dout1, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
            chk("b_rerst_valid", 32'(if_b.dout1_valid), 32'd0);
            chk("b_rerst_ready", 32'(if_b.ready), 32'(i >= 12));
        end
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd4);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        drv_b(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        chk("b_reinit_valid", 32'(if_b.dout1_valid), 32'd1);
        chk("b_reinit_data", if_b.dout1, 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
